// File: rtl/rf_pkg.sv
`default_nettype none
// rf_pkg: shared state encoding and core-default sizes for the multi-port register file.
// Revision 1.0
package rf_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// rf_scoreboard: per-register busy bits, issue-over-writeback priority, per-read-port lookup.
// Revision 1.0
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS    = RF_NREGS,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            clr,
  input  logic [1:0]      wr_en,
  input  logic [2*AW-1:0] wr_addr,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]  rd_busy
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  // Writeback clears are applied before the issue set so a same-index set wins.
  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < NREGS; i++) begin
      if (wr_en[0] && wr_addr[0 +: AW] == AW'(i)) busy_nxt[i] = 1'b0;
      if (wr_en[1] && wr_addr[AW +: AW] == AW'(i)) busy_nxt[i] = 1'b0;
      if (iss_en && iss_addr == AW'(i)) busy_nxt[i] = 1'b1;
    end
    if (clr) busy_nxt = '0;
    if (ZERO_REG) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_busy
    assign rd_busy[k] = run & busy[rd_addr[k*AW +: AW]];
  end

endmodule
`default_nettype wire

// File: rtl/regfile_mp_sb.sv
`default_nettype none
// regfile_mp_sb: NRD-read / 2-write register file with write bypass, busy scoreboard
// and a one-entry-per-cycle clear engine. Revision 1.0
module regfile_mp_sb
  import rf_pkg::*;
#(
  parameter int XLEN     = RF_XLEN,
  parameter int NREGS    = RF_NREGS,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_req,
  output logic                ready,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [1:0]          wr_en,
  input  logic [2*AW-1:0]     wr_addr,
  input  logic [2*XLEN-1:0]   wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr
);

  rf_state_t       state;
  logic [AW-1:0]   clr_idx;
  logic [XLEN-1:0] mem [NREGS];
  logic            run;
  logic [1:0]      wr_ok;

  assign run = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_idx <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + AW'(1);
          if (clr_idx == AW'(NREGS - 1)) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          if (clr_req) begin
            state   <= CLEAR;
            clr_idx <= '0;
            ready   <= 1'b0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // A write lane is effective only in RUN and never onto a hardwired zero register.
  for (genvar w = 0; w < 2; w++) begin : g_wr
    assign wr_ok[w] = run & wr_en[w] & ~(ZERO_REG && wr_addr[w*AW +: AW] == '0);
  end

  // No reset on the array; lane 1 is written last so it wins a same-index collision.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[clr_idx] <= '0;
    end else begin
      if (wr_ok[0]) mem[wr_addr[0 +: AW]]  <= wr_data[0 +: XLEN];
      if (wr_ok[1]) mem[wr_addr[AW +: AW]] <= wr_data[XLEN +: XLEN];
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] val;
    assign ra = rd_addr[k*AW +: AW];
    always_comb begin
      val = mem[ra];
      if (!run || (ZERO_REG && ra == '0))           val = '0;
      else if (wr_ok[1] && wr_addr[AW +: AW] == ra) val = wr_data[XLEN +: XLEN];
      else if (wr_ok[0] && wr_addr[0 +: AW] == ra)  val = wr_data[0 +: XLEN];
    end
    assign rd_data[k*XLEN +: XLEN] = val;
  end

  rf_scoreboard #(
    .NREGS    (NREGS),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .clr      (run & clr_req),
    .wr_en    (wr_en & {2{run}}),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en & run),
    .iss_addr (iss_addr),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy)
  );

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp_sb.sv
`default_nettype none
// tb_regfile_mp_sb: scoreboard-queue bench for regfile_mp_sb (XLEN=32, NREGS=32, NRD=2, ZERO_REG=1).
// Revision 1.0
module tb_regfile_mp_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                clr_req;
  logic                ready;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [1:0]          wr_en;
  logic [2*AW-1:0]     wr_addr;
  logic [2*XLEN-1:0]   wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;

  logic [31:0] exp_q[$];
  logic [31:0] e;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_mp_sb #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr)
  );

  task automatic idle();
    wr_en   = 2'b00;
    iss_en  = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic test_reset();
    int cnt;
    rst_n = 1'b0; idle(); rd_addr = '0; wr_addr = '0; wr_data = '0; iss_addr = '0;
    repeat (3) @(negedge clk);
    exp_q.push_back(32'd0);
    e = exp_q.pop_front(); checks++;
    if (ready !== e[0]) begin failures++; $display("FAIL reset_ready got=%0b exp=%0b", ready, e[0]); end
    rst_n = 1'b1;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 64) begin
      @(posedge clk); #1; cnt++;
      if (cnt == 16) begin
        exp_q.push_back(32'd0);
        e = exp_q.pop_front(); checks++;
        if (rd_data[0 +: XLEN] !== e || rd_busy !== 2'b00) begin
          failures++; $display("FAIL clear_read got=%0h busy=%0b exp=%0h", rd_data[0 +: XLEN], rd_busy, e);
        end
      end
    end
    exp_q.push_back(32'd32);
    e = exp_q.pop_front(); checks++;
    if (cnt !== int'(e)) begin failures++; $display("FAIL reset_clear_len got=%0d exp=%0d", cnt, e); end
    for (int i = 0; i < NREGS; i++) begin
      @(negedge clk);
      rd_addr = {AW'(i ^ 31), AW'(i)};
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      #1;
      e = exp_q.pop_front(); checks++;
      if (rd_data[0 +: XLEN] !== e || rd_busy[0] !== 1'b0) begin
        failures++; $display("FAIL init_read_p0 idx=%0d got=%0h busy=%0b exp=%0h", i, rd_data[0 +: XLEN], rd_busy[0], e);
      end
      e = exp_q.pop_front(); checks++;
      if (rd_data[XLEN +: XLEN] !== e || rd_busy[1] !== 1'b0) begin
        failures++; $display("FAIL init_read_p1 idx=%0d got=%0h busy=%0b exp=%0h", i ^ 31, rd_data[XLEN +: XLEN], rd_busy[1], e);
      end
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    wr_en = 2'b01; wr_addr = {AW'(0), AW'(5)}; wr_data = {32'h0, 32'hDEADBEEF};
    rd_addr = {AW'(5), AW'(5)};
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'hDEADBEEF);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd_data[0 +: XLEN] !== e) begin failures++; $display("FAIL bypass_p0 got=%0h exp=%0h", rd_data[0 +: XLEN], e); end
    e = exp_q.pop_front(); checks++;
    if (rd_data[XLEN +: XLEN] !== e) begin failures++; $display("FAIL bypass_p1 got=%0h exp=%0h", rd_data[XLEN +: XLEN], e); end
    @(negedge clk);
    idle();
    exp_q.push_back(32'hDEADBEEF);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd_data[0 +: XLEN] !== e) begin failures++; $display("FAIL array_x5 got=%0h exp=%0h", rd_data[0 +: XLEN], e); end
  endtask

  task automatic test_dual_write();
    @(negedge clk);
    wr_en = 2'b11; wr_addr = {AW'(7), AW'(7)}; wr_data = {32'h2222_2222, 32'h1111_1111};
    rd_addr = {AW'(5), AW'(7)};
    exp_q.push_back(32'h2222_2222);
    exp_q.push_back(32'hDEADBEEF);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd_data[0 +: XLEN] !== e) begin failures++; $display("FAIL dual_bypass got=%0h exp=%0h", rd_data[0 +: XLEN], e); end
    e = exp_q.pop_front(); checks++;
    if (rd_data[XLEN +: XLEN] !== e) begin failures++; $display("FAIL other_port got=%0h exp=%0h", rd_data[XLEN +: XLEN], e); end
    @(negedge clk);
    idle();
    exp_q.push_back(32'h2222_2222);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd_data[0 +: XLEN] !== e) begin failures++; $display("FAIL dual_array got=%0h exp=%0h", rd_data[0 +: XLEN], e); end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    wr_en = 2'b01; wr_addr = {AW'(0), AW'(0)}; wr_data = {32'h0, 32'hFFFF_FFFF};
    iss_en = 1'b1; iss_addr = '0;
    rd_addr = {AW'(0), AW'(0)};
    exp_q.push_back(32'd0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd_data[0 +: XLEN] !== e) begin failures++; $display("FAIL x0_bypass got=%0h exp=%0h", rd_data[0 +: XLEN], e); end
    @(negedge clk);
    idle();
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd_data[0 +: XLEN] !== e) begin failures++; $display("FAIL x0_array got=%0h exp=%0h", rd_data[0 +: XLEN], e); end
    e = exp_q.pop_front(); checks++;
    if ({31'd0, rd_busy[0]} !== e) begin failures++; $display("FAIL x0_busy got=%0b exp=%0h", rd_busy[0], e); end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    iss_en = 1'b1; iss_addr = AW'(3); rd_addr = {AW'(3), AW'(3)};
    exp_q.push_back(32'd0);
    #1;
    e = exp_q.pop_front(); checks++;
    if ({31'd0, rd_busy[0]} !== e) begin failures++; $display("FAIL busy_no_bypass got=%0b exp=%0h", rd_busy[0], e); end
    @(negedge clk);
    idle();
    exp_q.push_back(32'd1);
    #1;
    e = exp_q.pop_front(); checks++;
    if ({31'd0, rd_busy[0]} !== e) begin failures++; $display("FAIL busy_after_issue got=%0b exp=%0h", rd_busy[0], e); end
    @(negedge clk);
    wr_en = 2'b10; wr_addr = {AW'(3), AW'(0)}; wr_data = {32'hABCD_0003, 32'h0};
    iss_en = 1'b1; iss_addr = AW'(3);
    @(negedge clk);
    idle();
    exp_q.push_back(32'd1);
    exp_q.push_back(32'hABCD_0003);
    #1;
    e = exp_q.pop_front(); checks++;
    if ({31'd0, rd_busy[1]} !== e) begin failures++; $display("FAIL busy_set_wins got=%0b exp=%0h", rd_busy[1], e); end
    e = exp_q.pop_front(); checks++;
    if (rd_data[0 +: XLEN] !== e) begin failures++; $display("FAIL lane1_write got=%0h exp=%0h", rd_data[0 +: XLEN], e); end
    @(negedge clk);
    wr_en = 2'b01; wr_addr = {AW'(0), AW'(3)}; wr_data = {32'h0, 32'h0000_0033};
    @(negedge clk);
    idle();
    exp_q.push_back(32'd0);
    #1;
    e = exp_q.pop_front(); checks++;
    if ({31'd0, rd_busy[0]} !== e) begin failures++; $display("FAIL busy_cleared got=%0b exp=%0h", rd_busy[0], e); end
  endtask

  task automatic test_clr_hold();
    int cnt;
    @(negedge clk);
    clr_req = 1'b1;
    @(posedge clk); #1;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 64) begin
      @(posedge clk); #1; cnt++;
      if (cnt == 5) clr_req = 1'b0;
    end
    exp_q.push_back(32'd32);
    e = exp_q.pop_front(); checks++;
    if (cnt !== int'(e)) begin failures++; $display("FAIL clr_hold_len got=%0d exp=%0d", cnt, e); end
  endtask

  task automatic test_clear_reset();
    int cnt;
    @(negedge clk);
    wr_en = 2'b01; wr_addr = {AW'(0), AW'(9)}; wr_data = {32'h0, 32'h55};
    iss_en = 1'b1; iss_addr = AW'(4);
    @(negedge clk);
    idle();
    rd_addr = {AW'(4), AW'(9)};
    exp_q.push_back(32'h55);
    exp_q.push_back(32'd1);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd_data[0 +: XLEN] !== e) begin failures++; $display("FAIL x9_written got=%0h exp=%0h", rd_data[0 +: XLEN], e); end
    e = exp_q.pop_front(); checks++;
    if ({31'd0, rd_busy[1]} !== e) begin failures++; $display("FAIL x4_busy got=%0b exp=%0h", rd_busy[1], e); end
    @(negedge clk);
    clr_req = 1'b1;
    exp_q.push_back(32'd1);
    #1;
    e = exp_q.pop_front(); checks++;
    if ({31'd0, ready} !== e) begin failures++; $display("FAIL ready_before_clr got=%0b exp=%0h", ready, e); end
    @(negedge clk);
    clr_req = 1'b0;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    #1;
    e = exp_q.pop_front(); checks++;
    if ({31'd0, ready} !== e) begin failures++; $display("FAIL ready_drop got=%0b exp=%0h", ready, e); end
    e = exp_q.pop_front(); checks++;
    if (rd_data[0 +: XLEN] !== e || rd_busy !== 2'b00) begin
      failures++; $display("FAIL x9_during_clear got=%0h busy=%0b exp=%0h", rd_data[0 +: XLEN], rd_busy, e);
    end
    // clr_idx is 0 here; ten more edges bring it to 10.
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 64) begin
      @(posedge clk); #1; cnt++;
    end
    exp_q.push_back(32'd32);
    e = exp_q.pop_front(); checks++;
    if (cnt !== int'(e)) begin failures++; $display("FAIL restart_len got=%0d exp=%0d", cnt, e); end
    @(negedge clk);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd_data[0 +: XLEN] !== e) begin failures++; $display("FAIL x9_after_clear got=%0h exp=%0h", rd_data[0 +: XLEN], e); end
    e = exp_q.pop_front(); checks++;
    if ({31'd0, rd_busy[1]} !== e) begin failures++; $display("FAIL x4_busy_after got=%0b exp=%0h", rd_busy[1], e); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_dual_write();
    test_zero_reg();
    test_scoreboard();
    test_clr_hold();
    test_clear_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file for the next-generation core: NRD read ports and two write ports.
- Same-cycle write-to-read bypass.
- Per-register busy scoreboard for issue/writeback hazard tracking.
- Sequential clear engine that zeroes the array one entry per cycle, so the array carries no reset and can map to distributed RAM.
- Sits between decode/issue (reads, busy checks) and writeback (two retire lanes).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of two, >=2)
NRD, 2, number of read ports (>=1)
ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy; 0 = register 0 is ordinary
AW, $clog2(NREGS), register index width (derived, not overridden)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
clr_req  in  1  pulse: start a full array clear
ready  out  1  1 = array usable; 0 while clearing
rd_addr  in  NRD*AW  packed read indices, port k at [k*AW +: AW]
rd_data  out  NRD*XLEN  packed read data, combinational
rd_busy  out  NRD  busy bit of each addressed register, combinational
wr_en  in  2  per-lane write enable
wr_addr  in  2*AW  per-lane destination index
wr_data  in  2*XLEN  per-lane write data
iss_en  in  1  issue marks a destination busy
iss_addr  in  AW  destination being issued

Behaviour:
- Reset: rst_n low asynchronously forces state=CLEAR, clr_idx=0, all busy bits=0, ready=0. The array itself has no reset.
- FSM states: CLEAR, RUN.
  - CLEAR: each cycle writes 0 to entry clr_idx and increments clr_idx. When clr_idx==NREGS-1 is written, go to RUN next cycle. A full clear takes NREGS cycles from rst_n deassertion.
  - RUN: ready=1. clr_req=1 goes to CLEAR with clr_idx=0 and clears all busy bits on the same edge.
- clr_req held during CLEAR: no restart, clear continues.
- rst_n low mid-clear: restarts from index 0.
- During CLEAR:
  - wr_en and iss_en are ignored.
  - rd_data reads 0 and rd_busy reads 0 on all ports.
- Writes (RUN):
  - Lane w with wr_en[w]=1 writes wr_data to wr_addr on the clock edge.
  - With ZERO_REG=1, writes to index 0 are dropped.
  - Both lanes to the same index: lane 1 wins.
- Reads:
  - Fully combinational.
  - Index 0 with ZERO_REG=1 always reads 0.
  - Otherwise bypass priority: lane 1 write match, then lane 0 write match, then array contents.
  - Bypass applies only when wr_en is set, the state is RUN, and the index is non-zero (if ZERO_REG=1).
- Scoreboard (RUN):
  - wr_en[w] clears busy[wr_addr[w]]; iss_en sets busy[iss_addr].
  - Same index set and cleared in the same cycle: set wins.
  - busy[0] is held 0 when ZERO_REG=1.
  - rd_busy[k] reflects registered state only, with no bypass of same-cycle writes or issues.
- Latency: write visible via the array one cycle after the edge; visible via bypass in the same cycle.
- Width rules: all data is XLEN bits with no extension. Out-of-range indices are impossible because NREGS is a power of two.

Decomposition:
- Shared package rf_pkg holds the state enum (CLEAR, RUN) and the default XLEN and NREGS constants used by the core.
- One sub-module: rf_scoreboard (busy vector, set/clear priority, per-port lookup).
- Array, bypass and clear FSM stay in the top module.

Test Plan:
1. Release rst_n, NREGS=32:
   - ready stays 0 for 32 cycles then rises.
   - Reading all indices returns 0.
   - rd_busy=0 everywhere.
2. RUN:
   - Lane0 writes x5=0xDEADBEEF.
   - Same cycle: rd_addr[0]=5 returns 0xDEADBEEF via bypass.
   - Next cycle: returns 0xDEADBEEF from the array.
3. Both lanes write x7 (lane0=0x1111_1111, lane1=0x2222_2222):
   - Bypass and the later read both return 0x2222_2222.
4. Write 0xFFFF_FFFF to x0 with ZERO_REG=1:
   - x0 reads 0 in the same cycle and the next.
   - iss_addr=0 leaves rd_busy 0.
5. Scoreboard:
   - Issue x3, then rd_busy for x3 = 1.
   - Lane1 writes x3 while iss_en re-issues x3 in the same cycle: busy stays 1.
   - Later write without issue: busy 0.
6. After x9=0x55 is written:
   - Assert clr_req: ready drops the next cycle and x9 reads 0 during the clear.
   - Pull rst_n low at clr_idx=10: the clear restarts and ready returns 32 cycles after release.
   - x9 reads 0.
